// File: rtl/gmux_seq_ctrl.sv
// Global clock mux sequencer: staggered quadrant gate-off, settle, select change, staggered re-enable.
// Optional build macro GMUX_SEQ_VLP_EN adds per-quadrant low-power flags that track gated quadrants.
//
// state  | meaning
// IDLE   | ready for a request, outputs static
// GATE   | disabling quadrants high index to low, one per stagger interval
// SETTLE | all quadrants off, waiting out the settle interval
// SWITCH | select just loaded, waiting for the first enable step
// UNGATE | enabling masked quadrants low index to high
module gmux_seq_ctrl #(
    parameter int NUM_SRC     = 2,
    parameter int NUM_QUAD    = 4,
    parameter int STAGGER_CYC = 2,
    parameter int SETTLE_CYC  = 4,
    parameter int SELW        = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                REQ_VLD,
    input  logic [SELW-1:0]     REQ_SRC,
    input  logic [NUM_QUAD-1:0] REQ_QMASK,
    output logic                REQ_RDY,
    output logic [SELW-1:0]     SSEL,
    output logic [NUM_QUAD-1:0] SEN,
    output logic [NUM_QUAD-1:0] VLP,
    output logic                BUSY,
    output logic                DONE,
    output logic                ERR
);

    localparam int MAXC = (STAGGER_CYC > SETTLE_CYC) ? STAGGER_CYC : SETTLE_CYC;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int QW   = (NUM_QUAD > 1) ? $clog2(NUM_QUAD) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        GATE   = 3'd1,
        SETTLE = 3'd2,
        SWITCH = 3'd3,
        UNGATE = 3'd4
    } state_t;

    state_t                state;
    logic [CW-1:0]         cnt;
    logic [QW-1:0]         qidx;
    logic [SELW-1:0]       src_q;
    logic [NUM_QUAD-1:0]   mask_q;
    logic                  src_ok;

    assign src_ok = ({1'b0, REQ_SRC} < (SELW+1)'(NUM_SRC));

`ifndef GMUX_SEQ_VLP_EN
    assign VLP = '0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            cnt     <= '0;
            qidx    <= '0;
            src_q   <= '0;
            mask_q  <= '0;
            SSEL    <= '0;
            SEN     <= '0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
            ERR     <= 1'b0;
            REQ_RDY <= 1'b1;
`ifdef GMUX_SEQ_VLP_EN
            VLP     <= '0;
`endif
        end else begin
            DONE <= 1'b0;
            ERR  <= 1'b0;
            case (state)
                IDLE: begin
                    if (REQ_VLD) begin
                        if (src_ok) begin
                            src_q   <= REQ_SRC;
                            mask_q  <= REQ_QMASK;
                            BUSY    <= 1'b1;
                            REQ_RDY <= 1'b0;
                            // The top quadrant gates on the accepting edge itself.
                            SEN[NUM_QUAD-1] <= 1'b0;
`ifdef GMUX_SEQ_VLP_EN
                            VLP[NUM_QUAD-1] <= 1'b1;
`endif
                            if (NUM_QUAD == 1) begin
                                state <= SETTLE;
                                cnt   <= CW'(SETTLE_CYC - 1);
                            end else begin
                                state <= GATE;
                                qidx  <= QW'(NUM_QUAD - 2);
                                cnt   <= CW'(STAGGER_CYC - 1);
                            end
                        end else begin
                            ERR <= 1'b1;
                        end
                    end
                end
                GATE: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        SEN[qidx] <= 1'b0;
`ifdef GMUX_SEQ_VLP_EN
                        VLP[qidx] <= 1'b1;
`endif
                        if (qidx == '0) begin
                            state <= SETTLE;
                            cnt   <= CW'(SETTLE_CYC - 1);
                        end else begin
                            qidx <= qidx - 1'b1;
                            cnt  <= CW'(STAGGER_CYC - 1);
                        end
                    end
                end
                SETTLE: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        SSEL  <= src_q;
                        state <= SWITCH;
                        qidx  <= '0;
                        cnt   <= CW'(STAGGER_CYC - 1);
                    end
                end
                SWITCH, UNGATE: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        if (mask_q[qidx]) begin
                            SEN[qidx] <= 1'b1;
`ifdef GMUX_SEQ_VLP_EN
                            VLP[qidx] <= 1'b0;
`endif
                        end
                        if (qidx == QW'(NUM_QUAD - 1)) begin
                            state   <= IDLE;
                            BUSY    <= 1'b0;
                            DONE    <= 1'b1;
                            REQ_RDY <= 1'b1;
                        end else begin
                            state <= UNGATE;
                            qidx  <= qidx + 1'b1;
                            cnt   <= CW'(STAGGER_CYC - 1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gmux_seq_ctrl.sv
// Bench for gmux_seq_ctrl: a 4-quadrant/3-source instance and a 1-quadrant/S=1/T=1 instance,
// expected per-cycle outputs derived from the edge-timing formulas and queued as a scoreboard.
module tb_gmux_seq_ctrl;

`ifdef GMUX_SEQ_VLP_EN
    localparam bit VLP_ON = 1'b1;
`else
    localparam bit VLP_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       vld0, vld1;
    logic [1:0] src;
    logic [3:0] qmask;

    logic       rdy0, busy0, done0, err0;
    logic [1:0] ssel0;
    logic [3:0] sen0, vlp0;
    logic       rdy1, busy1, done1, err1;
    logic [0:0] ssel1, sen1, vlp1;

    always #5 clk = ~clk;

    gmux_seq_ctrl #(.NUM_SRC(3), .NUM_QUAD(4), .STAGGER_CYC(2), .SETTLE_CYC(4)) dut0 (
        .CLK(clk), .RST(rst), .REQ_VLD(vld0), .REQ_SRC(src), .REQ_QMASK(qmask),
        .REQ_RDY(rdy0), .SSEL(ssel0), .SEN(sen0), .VLP(vlp0),
        .BUSY(busy0), .DONE(done0), .ERR(err0)
    );

    gmux_seq_ctrl #(.NUM_SRC(2), .NUM_QUAD(1), .STAGGER_CYC(1), .SETTLE_CYC(1)) dut1 (
        .CLK(clk), .RST(rst), .REQ_VLD(vld1), .REQ_SRC(src[0:0]), .REQ_QMASK(qmask[0:0]),
        .REQ_RDY(rdy1), .SSEL(ssel1), .SEN(sen1), .VLP(vlp1),
        .BUSY(busy1), .DONE(done1), .ERR(err1)
    );

    typedef struct packed {
        logic [1:0] ssel;
        logic [3:0] sen;
        logic [3:0] vlp;
        logic       busy;
        logic       done;
        logic       rdy;
        logic       err;
    } obs_t;

    typedef struct {
        logic [1:0] src;
        logic [3:0] mask;
        bit         noise;
        bit         is_err;
        logic [1:0] exp_ssel;
        logic [3:0] exp_sen;
        logic [3:0] exp_vlp;
    } vec_t;

    obs_t exp_q[$];
    obs_t prev[2];
    obs_t reset_obs;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic obs_t observe(input int d);
        obs_t a;
        if (d == 0) begin
            a.ssel = ssel0; a.sen = sen0; a.vlp = vlp0;
            a.busy = busy0; a.done = done0; a.rdy = rdy0; a.err = err0;
        end else begin
            a.ssel = {1'b0, ssel1}; a.sen = {3'b000, sen1}; a.vlp = {3'b000, vlp1};
            a.busy = busy1; a.done = done1; a.rdy = rdy1; a.err = err1;
        end
        return a;
    endfunction

    // Expected outputs after edge k+e of a sequence accepted at edge k.
    function automatic obs_t model(input int e, input int n, input int s, input int t,
                                   input logic [1:0] s_src, input logic [3:0] s_mask,
                                   input obs_t p);
        obs_t o;
        int   ts;
        int   fin;
        ts  = (n - 1) * s + t;
        fin = ts + n * s;
        o      = p;
        o.err  = 1'b0;
        o.done = (e == fin);
        o.busy = (e < fin);
        o.rdy  = (e >= fin);
        if (e >= ts) o.ssel = s_src;
        for (int j = 0; j < n; j++) begin
            if (e >= ts + (j + 1) * s) begin
                o.sen[j] = s_mask[j];
                o.vlp[j] = s_mask[j] ? 1'b0 : VLP_ON;
            end else if (e >= (n - 1 - j) * s) begin
                o.sen[j] = 1'b0;
                o.vlp[j] = VLP_ON;
            end
        end
        return o;
    endfunction

    task automatic check_obs(input int d, input string tag);
        obs_t e;
        obs_t a;
        if (exp_q.size() == 0) begin
            chk({tag, " scoreboard_empty"}, 0, 1);
            return;
        end
        e = exp_q.pop_front();
        a = observe(d);
        chk({tag, " SSEL"},    int'(a.ssel), int'(e.ssel));
        chk({tag, " SEN"},     int'(a.sen),  int'(e.sen));
        chk({tag, " VLP"},     int'(a.vlp),  int'(e.vlp));
        chk({tag, " BUSY"},    int'(a.busy), int'(e.busy));
        chk({tag, " DONE"},    int'(a.done), int'(e.done));
        chk({tag, " REQ_RDY"}, int'(a.rdy),  int'(e.rdy));
        chk({tag, " ERR"},     int'(a.err),  int'(e.err));
    endtask

    task automatic set_vld(input int d, input logic v);
        vld0 = (d == 0) ? v : 1'b0;
        vld1 = (d == 1) ? v : 1'b0;
    endtask

    task automatic run_seq(input int d, input logic [1:0] s_src, input logic [3:0] s_mask,
                           input bit noise, input int rst_at, input string tag);
        int   n, s, t, fin;
        obs_t e;
        n   = (d == 0) ? 4 : 1;
        s   = (d == 0) ? 2 : 1;
        t   = (d == 0) ? 4 : 1;
        fin = (n - 1) * s + t + n * s;
        for (int k = 0; k <= fin; k++) begin
            if (k == 0) begin
                src = s_src; qmask = s_mask; set_vld(d, 1'b1);
            end else if (noise) begin
                src = 2'($urandom_range(0, 3)); qmask = 4'($urandom_range(0, 15)); set_vld(d, 1'b1);
            end else begin
                set_vld(d, 1'b0);
            end
            if (k == rst_at) rst = 1'b1;
            e = (k == rst_at) ? reset_obs : model(k, n, s, t, s_src, s_mask, prev[d]);
            exp_q.push_back(e);
            @(posedge clk);
            @(negedge clk);
            check_obs(d, $sformatf("%s e%0d", tag, k));
            if (k == rst_at) begin
                rst = 1'b0;
                set_vld(d, 1'b0);
                prev[0] = reset_obs;
                prev[1] = reset_obs;
                return;
            end
            prev[d] = e;
        end
    endtask

    task automatic run_err(input int d, input string tag);
        obs_t e;
        src = 2'd3; qmask = 4'($urandom_range(0, 15)); set_vld(d, 1'b1);
        e = prev[d]; e.err = 1'b1; e.done = 1'b0; e.busy = 1'b0; e.rdy = 1'b1;
        exp_q.push_back(e);
        @(posedge clk); @(negedge clk);
        check_obs(d, {tag, " reject"});
        set_vld(d, 1'b0);
        e.err = 1'b0;
        exp_q.push_back(e);
        @(posedge clk); @(negedge clk);
        check_obs(d, {tag, " after"});
        prev[d] = e;
    endtask

    vec_t vt[5];

    initial begin
        obs_t a;
        reset_obs = '{ssel: 2'd0, sen: 4'h0, vlp: 4'h0, busy: 1'b0, done: 1'b0, rdy: 1'b1, err: 1'b0};
        vt[0] = '{2'd1, 4'hF, 1'b0, 1'b0, 2'd1, 4'hF, 4'h0};
        vt[1] = '{2'd0, 4'h5, 1'b0, 1'b0, 2'd0, 4'h5, VLP_ON ? 4'hA : 4'h0};
        vt[2] = '{2'd3, 4'hF, 1'b0, 1'b1, 2'd0, 4'h5, VLP_ON ? 4'hA : 4'h0};
        vt[3] = '{2'd2, 4'h3, 1'b1, 1'b0, 2'd2, 4'h3, VLP_ON ? 4'hC : 4'h0};
        vt[4] = '{2'd1, 4'hF, 1'b0, 1'b0, 2'd1, 4'hF, 4'h0};

        rst = 1'b1; vld0 = 1'b0; vld1 = 1'b0; src = 2'd0; qmask = 4'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        exp_q.push_back(reset_obs);
        check_obs(0, "reset d0");
        exp_q.push_back(reset_obs);
        check_obs(1, "reset d1");
        rst = 1'b0;
        prev[0] = reset_obs;
        prev[1] = reset_obs;

        // Back-to-back vectors: each request is offered on the cycle right after DONE.
        for (int v = 0; v < 5; v++) begin
            if (vt[v].is_err) run_err(0, $sformatf("v%0d", v));
            else run_seq(0, vt[v].src, vt[v].mask, vt[v].noise, -1, $sformatf("v%0d", v));
            a = observe(0);
            chk($sformatf("v%0d final SSEL", v), int'(a.ssel), int'(vt[v].exp_ssel));
            chk($sformatf("v%0d final SEN", v),  int'(a.sen),  int'(vt[v].exp_sen));
            chk($sformatf("v%0d final VLP", v),  int'(a.vlp),  int'(vt[v].exp_vlp));
        end

        // Reset during SETTLE abandons the sequence with no DONE.
        run_seq(0, 2'd2, 4'hF, 1'b0, 8, "rst_mid");
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(reset_obs);
            @(posedge clk); @(negedge clk);
            check_obs(0, $sformatf("rst_idle%0d", i));
        end

        // Single quadrant, minimal stagger and settle.
        run_seq(1, 2'd1, 4'h1, 1'b0, -1, "q1a");
        a = observe(1);
        chk("q1a final SSEL", int'(a.ssel), 1);
        chk("q1a final SEN",  int'(a.sen),  1);
        run_seq(1, 2'd0, 4'h0, 1'b0, -1, "q1b");
        a = observe(1);
        chk("q1b final SSEL", int'(a.ssel), 0);
        chk("q1b final SEN",  int'(a.sen),  0);
        chk("q1b final VLP",  int'(a.vlp),  int'(VLP_ON));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
